// File: rtl/dromajo_write_pkg.sv
// Shared definitions for the co-simulation memory-override write sequencer.
//   BEAT_BYTES   : bytes per beat (fixed at 8)
//   SIZE_*       : log2(piece bytes) encodings driven on out_size
//   state_t      : sequencer FSM states
//   next_piece() : picks the next naturally aligned piece out of a byte mask
package dromajo_write_pkg;

  localparam int         BEAT_BYTES = 8;
  localparam logic [2:0] SIZE_1B    = 3'd0;
  localparam logic [2:0] SIZE_2B    = 3'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [2:0] SIZE_8B    = 3'd3;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  typedef struct packed {
    logic [2:0] p;     // byte offset of the piece within the beat
    logic [2:0] size;  // log2 of the piece length in bytes
  } piece_t;

  // Lowest set byte p, then the largest power-of-two run starting at p that
  // is both aligned to its own length and fully covered by the mask.
  // An empty mask returns {0, SIZE_1B}; callers never emit in that case.
  function automatic piece_t next_piece(input logic [BEAT_BYTES-1:0] mask);
    piece_t                pc;
    logic [BEAT_BYTES-1:0] m;
    pc.p    = '0;
    pc.size = SIZE_1B;
    for (int i = BEAT_BYTES - 1; i >= 0; i--)
      if (mask[i]) pc.p = 3'(i);
    m = mask >> pc.p;
    if (pc.p == 3'd0 && m == 8'hFF)              pc.size = SIZE_8B;
    else if (pc.p[1:0] == 2'b00 && m[3:0] == 4'hF) pc.size = SIZE_4B;
    else if (pc.p[0] == 1'b0 && m[1:0] == 2'b11)   pc.size = SIZE_2B;
    else                                            pc.size = SIZE_1B;
    return pc;
  endfunction

endpackage

// File: rtl/dromajo_rr_arbiter.sv
// Round-robin grant selection. Searches ptr+1, ptr+2, ... modulo N_REQ and
// grants the first valid requester. The pointer register lives in the parent.
//   valid     : per-requester request valid
//   ptr       : index of the most recent winner
//   en        : arbitration enable; no grant when low
//   grant     : one-hot grant (all zero when nothing granted)
//   grant_idx : index of the granted requester
module dromajo_rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (en && !found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dromajo_write_sequencer.sv
// Shares the DPI memory-override write port among N_REQ requesters.
// One byte-masked beat is accepted per IDLE cycle (round robin), then split
// into naturally aligned 1/2/4/8-byte writes, one per cycle, in SPLIT.
//   clock, reset : clock, synchronous active-low reset
//   req_valid/req_ready/req_addr/req_mask/req_data : per-requester beat
//                  channels, flattened with requester i at slice i
//   out_valid/out_addr/out_size/out_data : write pulse to the writer
//                  (no backpressure); data right-justified, upper bytes zero
//   busy         : high while pieces of a beat remain (SPLIT)
module dromajo_write_sequencer
  import dromajo_write_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*8-1:0]         req_mask,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [2:0]                 out_size,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0][ADDR_W-1:0]     addr_v;
  logic [N_REQ-1:0][BEAT_BYTES-1:0] mask_v;
  logic [N_REQ-1:0][DATA_W-1:0]     data_v;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_v[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign mask_v[i] = req_mask[i*BEAT_BYTES +: BEAT_BYTES];
    assign data_v[i] = req_data[i*DATA_W +: DATA_W];
  end

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      rr_ptr, grant_idx;
  logic [N_REQ-1:0]      grant;
  logic [ADDR_W-4:0]     addr_hi;
  logic [BEAT_BYTES-1:0] mask_q, mask_left, k_mask;
  logic [DATA_W-1:0]     data_q, keep;
  logic [ADDR_W-1:0]     sel_addr;
  logic [BEAT_BYTES-1:0] sel_mask;
  logic [DATA_W-1:0]     sel_data;
  logic                  arb_en, accept, emit;
  piece_t                piece;
  logic                  unused_addr_lo;

  // Arbitration only in IDLE and never while reset is held.
  assign arb_en = (state == IDLE) && reset;

  dromajo_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_addr       = addr_v[grant_idx];
  assign sel_mask       = mask_v[grant_idx];
  assign sel_data       = data_v[grant_idx];
  assign unused_addr_lo = &{1'b0, sel_addr[2:0]};

  // Piece selection and the bytes it retires from the latched mask.
  assign piece = next_piece(mask_q);

  always_comb begin
    k_mask = 8'h01;
    keep   = DATA_W'(64'hFF);
    case (piece.size)
      SIZE_2B: begin k_mask = 8'h03; keep = DATA_W'(64'hFFFF);               end
      SIZE_4B: begin k_mask = 8'h0F; keep = DATA_W'(64'hFFFF_FFFF);          end
      SIZE_8B: begin k_mask = 8'hFF; keep = DATA_W'(64'hFFFF_FFFF_FFFF_FFFF); end
      default: begin k_mask = 8'h01; keep = DATA_W'(64'hFF);                 end
    endcase
  end

  assign mask_left = mask_q & ~(k_mask << piece.p);

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state. An empty-mask beat is consumed without leaving IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && sel_mask != '0) state_nxt = SPLIT;
      SPLIT:   if (mask_left == '0)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = grant;
    accept    = |grant;
    emit      = (state == SPLIT);
    busy      = (state == SPLIT);
  end

  // Datapath: beat latch, round-robin pointer and registered write port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr    <= PTR_W'(N_REQ - 1);
      addr_hi   <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_size  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        rr_ptr  <= grant_idx;
        addr_hi <= sel_addr[ADDR_W-1:3];
        mask_q  <= sel_mask;
        data_q  <= sel_data;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_addr  <= {addr_hi, piece.p};
        out_size  <= piece.size;
        out_data  <= (data_q >> {piece.p, 3'b000}) & keep;
        mask_q    <= mask_left;
      end
    end
  end

endmodule

// File: tb/tb_dromajo_write_sequencer.sv
module tb_dromajo_write_sequencer;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*8-1:0]      req_mask;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    out_valid;
  logic [ADDR_W-1:0]       out_addr;
  logic [2:0]              out_size;
  logic [DATA_W-1:0]       out_data;
  logic                    busy;

  always #5 clock = ~clock;

  dromajo_write_sequencer #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_mask  (req_mask),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_size  (out_size),
    .out_data  (out_data),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
  } pc_t;

  pc_t  m_q[$];
  pc_t  m_cur;
  logic m_valid = 1'b0;
  int   m_ptr   = N_REQ - 1;

  function automatic pc_t pc(input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
    pc_t r;
    r.addr = a; r.size = s; r.data = d;
    return r;
  endfunction

  function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int i = 1; i <= N_REQ; i++)
      if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    return -1;
  endfunction

  // Greedy split: lowest byte first, biggest aligned fully-covered run.
  function automatic void split_beat(input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
    logic [7:0]  rem;
    logic [63:0] dd;
    int          p, k, lg;
    logic        ok;
    rem = m;
    while (rem != 0) begin
      p = 0;
      while (!rem[p]) p++;
      k = 8;
      while (k > 1) begin
        ok = (p % k == 0);
        for (int b = p; b < p + k; b++)
          if (b > 7) ok = 1'b0; else if (!rem[b]) ok = 1'b0;
        if (ok) break;
        k = k / 2;
      end
      lg = (k == 8) ? 3 : (k == 4) ? 2 : (k == 2) ? 1 : 0;
      dd = d >> (8 * p);
      if (k < 8) dd = dd & ((64'd1 << (8 * k)) - 64'd1);
      m_q.push_back(pc({a[31:3], 3'b000} + 32'(p), 3'(lg), dd));
      for (int b = p; b < p + k; b++) rem[b] = 1'b0;
    end
  endfunction

  always @(posedge clock) begin
    int g;
    if (!reset) begin
      m_q.delete();
      m_ptr   = N_REQ - 1;
      m_valid = 1'b0;
    end else if (m_q.size() == 0) begin
      m_valid = 1'b0;
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_ptr = g;
        split_beat(req_addr[g*32 +: 32], req_mask[g*8 +: 8], req_data[g*64 +: 64]);
      end
    end else begin
      m_cur   = m_q.pop_front();
      m_valid = 1'b1;
    end
  end

  always @(negedge clock) begin
    logic [N_REQ-1:0] exp_r;
    int g;
    exp_r = '0;
    if (reset === 1'b1 && m_q.size() == 0) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) exp_r[g] = 1'b1;
    end
    chk("mon_ready", 64'(req_ready), 64'(exp_r));
    chk("mon_out_valid", 64'(out_valid), 64'(m_valid));
    chk("mon_busy", 64'(busy), 64'(m_q.size() != 0));
    if (m_valid) begin
      chk("mon_addr", 64'(out_addr), 64'(m_cur.addr));
      chk("mon_size", 64'(out_size), 64'(m_cur.size));
      chk("mon_data", out_data, m_cur.data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [7:0] m, input logic [63:0] d);
    req_valid[i]       = v;
    req_addr[i*32 +: 32] = a;
    req_mask[i*8 +: 8]   = m;
    req_data[i*64 +: 64] = d;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    do begin @(negedge clock); n++; end while (!req_ready[i] && n < 20);
    chk($sformatf("ready%0d_wait", i), 64'(req_ready[i]), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clock); n++; end while ((busy || out_valid) && n < 50);
    chk("wait_idle", 64'(busy | out_valid), 64'd0);
  endtask

  typedef struct {
    int          req;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    int          n;
    pc_t         exp[4];
  } vec_t;

  vec_t vecs[7];

  task automatic mkv(input int v, input int r, input logic [31:0] a,
                     input logic [7:0] m, input logic [63:0] d, input int n);
    vecs[v].req = r; vecs[v].addr = a; vecs[v].mask = m; vecs[v].data = d; vecs[v].n = n;
  endtask

  // Drive one beat alone, then check each piece on consecutive cycles,
  // starting two cycles after the ready cycle.
  task automatic apply_vec(input int v);
    vec_t t;
    t = vecs[v];
    @(posedge clock); #1;
    set_req(t.req, 1'b1, t.addr, t.mask, t.data);
    wait_ready(t.req);
    @(posedge clock); #1;
    req_valid[t.req] = 1'b0;
    @(negedge clock);
    chk($sformatf("v%0d_gap", v), 64'(out_valid), 64'd0);
    for (int j = 0; j < t.n; j++) begin
      @(negedge clock);
      chk($sformatf("v%0d_p%0d_valid", v, j), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_p%0d_addr", v, j), 64'(out_addr), 64'(t.exp[j].addr));
      chk($sformatf("v%0d_p%0d_size", v, j), 64'(out_size), 64'(t.exp[j].size));
      chk($sformatf("v%0d_p%0d_data", v, j), out_data, t.exp[j].data);
    end
    @(negedge clock);
    chk($sformatf("v%0d_end_valid", v), 64'(out_valid), 64'd0);
    chk($sformatf("v%0d_end_busy", v), 64'(busy), 64'd0);
  endtask

  initial begin
    int         gl[$];
    logic [1:0] rs;
    reset = 1'b0; req_valid = '1; req_addr = '0; req_mask = '1; req_data = '0;

    mkv(0, 0, 32'h8000_1000, 8'hFF, 64'h1122_3344_5566_7788, 1);
    vecs[0].exp[0] = pc(32'h8000_1000, 3'd3, 64'h1122_3344_5566_7788);
    mkv(1, 0, 32'h0000_1008, 8'h7E, 64'h0807_0605_0403_0201, 4);
    vecs[1].exp[0] = pc(32'h1009, 3'd0, 64'h02);
    vecs[1].exp[1] = pc(32'h100A, 3'd1, 64'h0403);
    vecs[1].exp[2] = pc(32'h100C, 3'd1, 64'h0605);
    vecs[1].exp[3] = pc(32'h100E, 3'd0, 64'h07);
    mkv(2, 1, 32'h0000_2000, 8'hF0, 64'hAABB_CCDD_1122_3344, 1);
    vecs[2].exp[0] = pc(32'h2004, 3'd2, 64'hAABB_CCDD);
    mkv(3, 1, 32'h0000_3000, 8'hAA, 64'h0807_0605_0403_0201, 4);
    vecs[3].exp[0] = pc(32'h3001, 3'd0, 64'h02);
    vecs[3].exp[1] = pc(32'h3003, 3'd0, 64'h04);
    vecs[3].exp[2] = pc(32'h3005, 3'd0, 64'h06);
    vecs[3].exp[3] = pc(32'h3007, 3'd0, 64'h08);
    mkv(4, 0, 32'h0000_4005, 8'h3C, 64'h8877_6655_4433_2211, 2);
    vecs[4].exp[0] = pc(32'h4002, 3'd1, 64'h4433);
    vecs[4].exp[1] = pc(32'h4004, 3'd1, 64'h6655);
    mkv(5, 1, 32'h0000_5000, 8'h01, 64'hDEAD_BEEF_CAFE_F00D, 1);
    vecs[5].exp[0] = pc(32'h5000, 3'd0, 64'h0D);
    mkv(6, 0, 32'h0000_600F, 8'hC0, 64'h1234_5678_9ABC_DEF0, 1);
    vecs[6].exp[0] = pc(32'h600E, 3'd1, 64'h1234);

    // reset state, with requests pending
    @(negedge clock);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_size", 64'(out_size), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1; req_valid = '0;

    for (int v = 0; v < 7; v++) apply_vec(v);

    // empty mask: consumed without output, next beat accepted right after
    @(posedge clock); #1;
    set_req(1, 1'b1, 32'h9000, 8'h00, 64'h0);
    wait_ready(1);
    chk("mask0_no_out0", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 32'h6000, 8'h01, 64'h5A);
    @(negedge clock);
    chk("mask0_next_ready", 64'(req_ready), 64'b01);
    chk("mask0_no_out1", 64'(out_valid), 64'd0);
    chk("mask0_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();

    // reset during the second piece of a 0x55 beat
    @(posedge clock); #1;
    set_req(0, 1'b1, 32'h7000, 8'h55, 64'h0807_0605_0403_0201);
    wait_ready(0);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rmid_p0_addr", 64'(out_addr), 64'h7000);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rmid_p1_valid", 64'(out_valid), 64'd1);
    chk("rmid_p1_addr", 64'(out_addr), 64'h7002);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("rmid_quiet_valid", 64'(out_valid), 64'd0);
      chk("rmid_quiet_busy", 64'(busy), 64'd0);
    end
    @(posedge clock); #1;
    set_req(0, 1'b1, 32'hA000, 8'hFF, 64'h1);
    set_req(1, 1'b1, 32'hB000, 8'h0F, 64'h2);
    @(negedge clock);
    chk("rmid_first_grant", 64'(req_ready), 64'b01);
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();

    // F0 beat on requester 1 straight after a reset
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    apply_vec(2);

    // both requesters streaming 0x0F beats: grants alternate from 0
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    set_req(0, 1'b1, 32'h0100, 8'h0F, 64'h1111_2222_3333_4444);
    set_req(1, 1'b1, 32'h0208, 8'h0F, 64'h5555_6666_7777_8888);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (req_ready[0]) gl.push_back(0);
      if (req_ready[1]) gl.push_back(1);
      if (c >= 2) chk($sformatf("alt_valid_c%0d", c), 64'(out_valid), 64'(c % 2 == 0));
      if (out_valid) begin
        chk("alt_size", 64'(out_size), 64'd2);
        chk("alt_addr_lo", 64'(out_addr[2:0]), 64'd0);
      end
    end
    chk("alt_grant_count", 64'(gl.size() >= 4), 64'd1);
    for (int j = 0; j < 4 && j < gl.size(); j++)
      chk($sformatf("alt_grant%0d", j), 64'(gl[j]), 64'(j % 2));
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      rs = req_ready;
      @(posedge clock); #1;
      for (int i = 0; i < N_REQ; i++) begin
        logic [7:0] m;
        case ($urandom_range(0, 5))
          0: m = 8'h00;
          1: m = 8'hFF;
          2: m = 8'h55;
          3: m = 8'hAA;
          default: m = 8'($urandom);
        endcase
        if (req_valid[i] && rs[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, $urandom, m, {$urandom, $urandom});
          else
            req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, $urandom, m, {$urandom, $urandom});
        end
      end
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      else reset = 1'b1;
    end
    @(posedge clock); #1;
    reset = 1'b1; req_valid = '0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
